// File: rtl/psa_sub_serial_if.sv
// ---------------------------------------------------------------------------
// | Module   : psa_sub_serial_if                                              |
// | Brief    : Request/result bundle for the nibble-serial partitioned        |
// |            saturating subtractor.                                        |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

interface psa_sub_serial_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
);
    logic                      start;
    logic [LANES*LANE_W-1:0]   A;
    logic [LANES*LANE_W-1:0]   B;
    logic                      busy;
    logic                      done;
    logic [LANES*LANE_W-1:0]   Diff;
    logic [LANES-1:0]          LaneErr;
    logic                      Error;

    // Requester side
    modport master (
        output start, A, B,
        input  busy, done, Diff, LaneErr, Error
    );

    // Subtractor side
    modport slave (
        input  start, A, B,
        output busy, done, Diff, LaneErr, Error
    );
endinterface

`default_nettype wire

// File: rtl/psa_sub_serial.sv
// ---------------------------------------------------------------------------
// | Module   : psa_sub_serial                                                 |
// | Brief    : Sequential partitioned subtractor. Computes A - B in LANES    |
// |            independent signed lanes, one lane per clock, lane 0 first,   |
// |            with per-lane overflow flags and an aggregate Error.          |
// |            Build option PSA_SUB_SAT_EN: overflowing lanes saturate to    |
// |            the largest/smallest signed lane value instead of wrapping.   |
// | Revision : 1.0  initial release                                          |
// ---------------------------------------------------------------------------
`default_nettype none

module psa_sub_serial #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    psa_sub_serial_if.slave    bus
);

    localparam int c_W  = LANES * LANE_W;
    localparam int c_CW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(LANES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [c_CW-1:0]   r_cnt;
    logic [c_W-1:0]    r_a;
    logic [c_W-1:0]    r_b;
    logic [c_W-1:0]    r_diff;
    logic [LANES-1:0]  r_lane_err;
    logic              r_error;

    logic              w_accept;
    logic              w_last;
    logic [LANE_W-1:0] w_a_lane;
    logic [LANE_W-1:0] w_b_lane;
    logic [LANE_W-1:0] w_raw;
    logic              w_ovf;
    logic [LANE_W-1:0] w_res;
    logic [c_W-1:0]    w_diff_next;
    logic [LANES-1:0]  w_err_next;

    // A request is only taken when no lanes are in flight
    assign w_accept = bus.start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_cnt == c_LAST);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (bus.start) w_next_state = c_BUSY;
            c_BUSY:  if (w_last)    w_next_state = c_DONE;
            c_DONE:  w_next_state = bus.start ? c_BUSY : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // Select the current lane of the latched operands
    always_comb begin
        w_a_lane = '0;
        w_b_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_cnt == c_CW'(i)) begin
                w_a_lane = r_a[i*LANE_W +: LANE_W];
                w_b_lane = r_b[i*LANE_W +: LANE_W];
            end
        end
    end

    // Lane subtract. The low LANE_W bits of the extended difference equal the
    // plain modular difference, and overflow only needs the sign of that
    // truncated result, so the extra sign bit is never materialised.
    always_comb begin
        w_raw = w_a_lane - w_b_lane;
        w_ovf = (w_a_lane[LANE_W-1] != w_b_lane[LANE_W-1]) &&
                (w_raw[LANE_W-1]    != w_a_lane[LANE_W-1]);
`ifdef PSA_SUB_SAT_EN
        if (w_ovf) begin
            // Minuend sign decides the direction: a >= 0 overflowed upward
            w_res = w_a_lane[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                       : {1'b0, {(LANE_W-1){1'b1}}};
        end else begin
            w_res = w_raw;
        end
`else
        w_res = w_raw;
`endif
    end

    // Merge the fresh lane into the running result vectors
    always_comb begin
        w_diff_next = r_diff;
        w_err_next  = r_lane_err;
        for (int i = 0; i < LANES; i++) begin
            if (r_cnt == c_CW'(i)) begin
                w_diff_next[i*LANE_W +: LANE_W] = w_res;
                w_err_next[i]                   = w_ovf;
            end
        end
    end

    // Operand capture, lane counter and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_diff     <= '0;
            r_lane_err <= '0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
        end else if (w_accept) begin
            r_a        <= bus.A;
            r_b        <= bus.B;
            r_diff     <= '0;
            r_lane_err <= '0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
        end else if (r_state == c_BUSY) begin
            r_diff     <= w_diff_next;
            r_lane_err <= w_err_next;
            r_error    <= |w_err_next;
            r_cnt      <= w_last ? '0 : r_cnt + c_CW'(1);
        end
    end

    assign bus.busy    = (r_state == c_BUSY);
    assign bus.done    = (r_state == c_DONE);
    assign bus.Diff    = r_diff;
    assign bus.LaneErr = r_lane_err;
    assign bus.Error   = r_error;

endmodule

`default_nettype wire
